glb_core_proc_router_pipe: RTL and testbench
============================================

GLB_CORE_PROC_ROUTER_PIPE -- requirements
Module: glb_core_proc_router_pipe

Interface
- REQ-001: Parameter NUM_PIPE, default 1, meaning request/passthrough pipeline stages per direction, legal range 1..4.
- REQ-002: Parameter RDRS_FIFO_DEPTH, default 4, meaning local read-response skid FIFO entries, power of 2, range 2..8.
- REQ-003: The block SHALL provide these ports:
  - clk  input  1  clock; all state is on the rising edge.
  - reset  input  1  asynchronous, active-low reset; asserted when 0.
  - glb_tile_id  input  TILE_SEL_ADDR_WIDTH  tile index; bit 0 selects the local direction.
  - packet_w2e_wsti  input  packet_t  west-to-east packet in.
  - packet_w2e_esto  output  packet_t  west-to-east packet out.
  - packet_e2w_esti  input  packet_t  east-to-west packet in.
  - packet_e2w_wsto  output  packet_t  east-to-west packet out.
  - wr_packet_pr2sw  output  wr_packet_t  write request to the core.
  - rdrq_packet_pr2sw  output  rdrq_packet_t  read request to the core.
  - rdrs_packet_sw2pr  input  rdrs_packet_t  read response from the core.
  - rdrs_fifo_full  output  1  skid FIFO full; the core throttles new read requests.
  - rdrs_overflow  output  1  sticky flag: a local response was dropped.
  - stat_collision_cnt  output  16  count of local responses deferred by a collision.

Function
- REQ-004: Local direction SHALL be w2e when glb_tile_id[0]==0 (even tile), otherwise e2w.
- REQ-005: The wr and rdrq fields of each direction SHALL pass through exactly NUM_PIPE register stages to the matching output.
- REQ-006: wr_packet_pr2sw and rdrq_packet_pr2sw SHALL equal the last-stage wr/rdrq of the local direction.
- REQ-007: The rdrs field of the non-local direction SHALL pass through NUM_PIPE stages unmodified.
- REQ-008: rdrs_packet_sw2pr SHALL be registered once before merge; "local response" means that registered value with rd_data_valid=1.
- REQ-009: The output slot SHALL be "free" when the last-stage passthrough rdrs of the local direction has rd_data_valid=0; a passthrough response SHALL always have priority.
- REQ-010: Free slot, FIFO empty, local response present: the local response SHALL be emitted that cycle (latency 1 from rdrs_packet_sw2pr) and SHALL NOT be enqueued.
- REQ-011: Free slot, FIFO non-empty: the FIFO head SHALL be popped and emitted; a simultaneous local response SHALL be pushed.
- REQ-012: Slot busy and local response present: the local response SHALL be pushed into the FIFO.
- REQ-013: Local responses SHALL be emitted in strict arrival order; no response SHALL be duplicated.
- REQ-014: A push when full with no pop in the same cycle SHALL drop the incoming response and set rdrs_overflow, which stays set until reset.
- REQ-015: A simultaneous push and pop when full SHALL be accepted, and the FIFO SHALL remain full.
- REQ-016: Read/write pointers SHALL be clog2(RDRS_FIFO_DEPTH)+1 bits and wrap modulo 2*RDRS_FIFO_DEPTH; full and empty SHALL be decoded from the MSB and index bits.
- REQ-017: rdrs_fifo_full SHALL be a registered-state decode with no combinational path from packet inputs.
- REQ-018: An emitted local response SHALL replace the whole rdrs field of the local-direction output; wr/rdrq fields SHALL be unaffected.

Reset
- REQ-019: While reset==0, all pipeline stages, the response register, FIFO pointers, rdrs_overflow and stat_collision_cnt SHALL clear to 0 asynchronously.
- REQ-020: During reset all packet outputs SHALL read 0, and rdrs_fifo_full SHALL read 0.
- REQ-021: Reset mid-operation SHALL discard FIFO contents; after reset release the first valid output SHALL appear no earlier than NUM_PIPE cycles for passthrough, or 1 cycle for a local response.
- REQ-022: FIFO storage data SHALL NOT require reset.

Configuration
- REQ-023: With GLB_PROC_ROUTER_STATS_EN defined, stat_collision_cnt SHALL increment by 1 on each REQ-012 push, including dropped pushes, and SHALL saturate at 16'hFFFF.
- REQ-024: Without GLB_PROC_ROUTER_STATS_EN, stat_collision_cnt SHALL be tied to 0, no counter logic SHALL exist, and the port list SHALL be unchanged.

Structure
- REQ-025: packet_t, wr_packet_t, rdrq_packet_t and rdrs_packet_t SHALL live in global_buffer_pkg.
- REQ-026: TILE_SEL_ADDR_WIDTH and the defaults PROC_PIPE_DEPTH=1 and PROC_RDRS_FIFO_DEPTH=4 SHALL live in global_buffer_param.
- REQ-027: The FIFO SHALL be one sub-module, glb_rdrs_fifo, parametrised by depth and data type, exposing push, pop, full, empty and head.

Verification
- REQ-028: Even tile, NUM_PIPE=2, w2e wr packet at cycle 0 -> identical on packet_w2e_esto.wr and wr_packet_pr2sw at cycle 2; e2w path unaffected.
- REQ-029: Odd tile, idle passthrough, local rdrs data 0xABCD -> appears on packet_e2w_wsto.rdrs 1 cycle later; FIFO stays empty.
- REQ-030: Even tile, passthrough valid for 3 cycles while 3 local responses A,B,C arrive -> A,B,C emitted in order in the 3 cycles after passthrough ends; stat_collision_cnt=3 when STATS_EN is defined.
- REQ-031: DEPTH=2, slot busy for 4 cycles with 3 local responses -> rdrs_fifo_full=1 after 2 pushes; the third is dropped; rdrs_overflow=1 and stays 1.
- REQ-032: FIFO full, slot frees while a new local response arrives -> head popped and new response pushed; FIFO stays full; no overflow.
- REQ-033: Assert reset with 2 entries queued -> all outputs 0 immediately; after release no stale response is emitted.

Source files
------------

// File: rtl/global_buffer_param.sv
// global_buffer_param: global-buffer widths and processor-router configuration defaults.
package global_buffer_param;
    localparam int TILE_SEL_ADDR_WIDTH  = 4;
    localparam int BANK_ADDR_WIDTH      = 16;
    localparam int BANK_DATA_WIDTH      = 32;
    localparam int BANK_STRB_WIDTH      = BANK_DATA_WIDTH / 8;
    localparam int PROC_PIPE_DEPTH      = 1;
    localparam int PROC_RDRS_FIFO_DEPTH = 4;
endpackage

// File: rtl/global_buffer_pkg.sv
// global_buffer_pkg: packet types carried on the processor router ring.
package global_buffer_pkg;
    import global_buffer_param::*;

    typedef struct packed {
        logic                       wr_en;
        logic [BANK_STRB_WIDTH-1:0] wr_strb;
        logic [BANK_ADDR_WIDTH-1:0] wr_addr;
        logic [BANK_DATA_WIDTH-1:0] wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                       rd_en;
        logic [BANK_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic [BANK_DATA_WIDTH-1:0] rd_data;
        logic                       rd_data_valid;
    } rdrs_packet_t;

    typedef struct packed {
        wr_packet_t   wr;
        rdrq_packet_t rdrq;
        rdrs_packet_t rdrs;
    } packet_t;
endpackage

// File: rtl/glb_rdrs_fifo.sv
// glb_rdrs_fifo: skid FIFO for deferred local read responses; wrap-bit pointers,
// storage is not reset. Push while full is accepted only together with a pop.
module glb_rdrs_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  T     din_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    T            mem_q [DEPTH];
    logic        do_pop, do_push;

    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/glb_core_proc_router_pipe.sv
// glb_core_proc_router_pipe: pipelined w2e/e2w processor router that taps the local
// direction and merges core read responses into free slots. Optional: GLB_PROC_ROUTER_STATS_EN.
module glb_core_proc_router_pipe
    import global_buffer_pkg::*;
    import global_buffer_param::*;
#(
    parameter int NUM_PIPE        = PROC_PIPE_DEPTH,
    parameter int RDRS_FIFO_DEPTH = PROC_RDRS_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
    input  packet_t                        packet_w2e_wsti,
    output packet_t                        packet_w2e_esto,
    input  packet_t                        packet_e2w_esti,
    output packet_t                        packet_e2w_wsto,
    output wr_packet_t                     wr_packet_pr2sw,
    output rdrq_packet_t                   rdrq_packet_pr2sw,
    input  rdrs_packet_t                   rdrs_packet_sw2pr,
    output logic                           rdrs_fifo_full,
    output logic                           rdrs_overflow,
    output logic [15:0]                    stat_collision_cnt
);
    packet_t      w2e_q [NUM_PIPE];
    packet_t      e2w_q [NUM_PIPE];
    packet_t      loc_pt;
    rdrs_packet_t rsp_q, fifo_head, merged_rdrs;
    logic         is_e2w, slot_free, loc_vld, fifo_empty, fifo_full, push, pop;
    logic         rdrs_overflow_q, rdrs_overflow_d, unused_tile;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < NUM_PIPE; i++) begin
                w2e_q[i] <= '0;
                e2w_q[i] <= '0;
            end
            rsp_q           <= '0;
            rdrs_overflow_q <= 1'b0;
        end else begin
            w2e_q[0]        <= packet_w2e_wsti;
            e2w_q[0]        <= packet_e2w_esti;
            for (int i = 1; i < NUM_PIPE; i++) begin
                w2e_q[i] <= w2e_q[i-1];
                e2w_q[i] <= e2w_q[i-1];
            end
            rsp_q           <= rdrs_packet_sw2pr;
            rdrs_overflow_q <= rdrs_overflow_d;
        end

    assign unused_tile = ^glb_tile_id[TILE_SEL_ADDR_WIDTH-1:1];
    assign is_e2w      = glb_tile_id[0];
    assign loc_pt      = is_e2w ? e2w_q[NUM_PIPE-1] : w2e_q[NUM_PIPE-1];
    assign slot_free   = !loc_pt.rdrs.rd_data_valid;
    assign loc_vld     = rsp_q.rd_data_valid;
    // a local response bypasses the FIFO only when it can go out immediately
    assign pop         = slot_free && !fifo_empty;
    assign push        = loc_vld && !(slot_free && fifo_empty);
    assign merged_rdrs = !slot_free ? loc_pt.rdrs : !fifo_empty ? fifo_head : loc_vld ? rsp_q : loc_pt.rdrs;
    assign rdrs_overflow_d = rdrs_overflow_q | (push && fifo_full && !pop);

    glb_rdrs_fifo #(.DEPTH(RDRS_FIFO_DEPTH), .T(rdrs_packet_t)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (rsp_q),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    always_comb begin
        packet_w2e_esto = w2e_q[NUM_PIPE-1];
        packet_e2w_wsto = e2w_q[NUM_PIPE-1];
        if (is_e2w) packet_e2w_wsto.rdrs = merged_rdrs;
        else packet_w2e_esto.rdrs = merged_rdrs;
    end

    assign wr_packet_pr2sw   = loc_pt.wr;
    assign rdrq_packet_pr2sw = loc_pt.rdrq;
    assign rdrs_fifo_full    = fifo_full;
    assign rdrs_overflow     = rdrs_overflow_q;

`ifdef GLB_PROC_ROUTER_STATS_EN
    logic [15:0] coll_cnt_q, coll_cnt_d;

    assign coll_cnt_d = (loc_vld && !slot_free && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) coll_cnt_q <= '0;
        else coll_cnt_q <= coll_cnt_d;

    assign stat_collision_cnt = coll_cnt_q;
`else
    assign stat_collision_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_glb_core_proc_router_pipe.sv
// tb_glb_core_proc_router_pipe: directed scenarios plus random traffic checked every
// cycle against a queue-based model of the router.
module tb_glb_core_proc_router_pipe;
    import global_buffer_pkg::*;
    import global_buffer_param::*;

    localparam int NP    = 2;
    localparam int DEPTH = 4;

    logic                           clk = 1'b0;
    logic                           reset = 1'b0;
    logic [TILE_SEL_ADDR_WIDTH-1:0] tile;
    packet_t                        w2e_in, e2w_in, w2e_out, e2w_out;
    wr_packet_t                     wr_out;
    rdrq_packet_t                   rdrq_out;
    rdrs_packet_t                   rsp_in;
    logic                           full, ovf;
    logic [15:0]                    stat;

    int total = 0;
    int bad   = 0;

    packet_t      m_w2e [$];
    packet_t      m_e2w [$];
    rdrs_packet_t m_fifo [$];
    rdrs_packet_t m_rsp;
    logic         m_ovf;
    int           m_coll;

    always #5 clk = ~clk;

    glb_core_proc_router_pipe #(.NUM_PIPE(NP), .RDRS_FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .glb_tile_id       (tile),
        .packet_w2e_wsti   (w2e_in),
        .packet_w2e_esto   (w2e_out),
        .packet_e2w_esti   (e2w_in),
        .packet_e2w_wsto   (e2w_out),
        .wr_packet_pr2sw   (wr_out),
        .rdrq_packet_pr2sw (rdrq_out),
        .rdrs_packet_sw2pr (rsp_in),
        .rdrs_fifo_full    (full),
        .rdrs_overflow     (ovf),
        .stat_collision_cnt(stat)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_clear();
        m_w2e  = {};
        m_e2w  = {};
        m_fifo = {};
        for (int i = 0; i < NP; i++) begin
            m_w2e.push_back('0);
            m_e2w.push_back('0);
        end
        m_rsp  = '0;
        m_ovf  = 1'b0;
        m_coll = 0;
    endfunction

    function automatic packet_t rnd_pkt(int pv);
        packet_t p;
        p.wr.wr_en              = 1'($urandom);
        p.wr.wr_strb            = 4'($urandom);
        p.wr.wr_addr            = 16'($urandom);
        p.wr.wr_data            = $urandom;
        p.rdrq.rd_en            = 1'($urandom);
        p.rdrq.rd_addr          = 16'($urandom);
        p.rdrs.rd_data          = $urandom;
        p.rdrs.rd_data_valid    = $urandom_range(99) < pv;
        return p;
    endfunction

    function automatic rdrs_packet_t mk_rsp(logic v, logic [31:0] d);
        rdrs_packet_t r;
        r.rd_data       = d;
        r.rd_data_valid = v;
        return r;
    endfunction

    // the packet leaving the local-direction pipe this cycle (oldest queued entry)
    function automatic packet_t m_local();
        return tile[0] ? m_e2w[0] : m_w2e[0];
    endfunction

    task automatic check_outputs();
        packet_t      lp, ew, ee;
        rdrs_packet_t out;
        logic [15:0]  exp_stat;
        lp = m_local();
        if (lp.rdrs.rd_data_valid) out = lp.rdrs;
        else if (m_fifo.size() > 0) out = m_fifo[0];
        else if (m_rsp.rd_data_valid) out = m_rsp;
        else out = lp.rdrs;
        ew = m_w2e[0];
        ee = m_e2w[0];
        if (tile[0]) ee.rdrs = out;
        else ew.rdrs = out;
`ifdef GLB_PROC_ROUTER_STATS_EN
        exp_stat = 16'(m_coll);
`else
        exp_stat = 16'h0;
`endif
        chk("w2e_esto", w2e_out, ew);
        chk("e2w_wsto", e2w_out, ee);
        chk("wr_pr2sw", wr_out, lp.wr);
        chk("rdrq_pr2sw", rdrq_out, lp.rdrq);
        chk("fifo_full", full, m_fifo.size() == DEPTH);
        chk("overflow", ovf, m_ovf);
        chk("stat", stat, exp_stat);
    endtask

    function automatic void m_edge();
        packet_t lp;
        logic    free, was_empty;
        lp        = m_local();
        free      = !lp.rdrs.rd_data_valid;
        was_empty = m_fifo.size() == 0;
        if (free && !was_empty) void'(m_fifo.pop_front());
        if (m_rsp.rd_data_valid && !(free && was_empty)) begin
            if (!free && m_coll < 65535) m_coll++;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(m_rsp);
            else m_ovf = 1'b1;
        end
        m_rsp = rsp_in;
        m_w2e.push_back(w2e_in);
        m_e2w.push_back(e2w_in);
        void'(m_w2e.pop_front());
        void'(m_e2w.pop_front());
    endfunction

    task automatic step(input packet_t a, input packet_t b, input rdrs_packet_t r);
        w2e_in = a;
        e2w_in = b;
        rsp_in = r;
        #1;
        check_outputs();
        m_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        w2e_in = rnd_pkt(100);
        e2w_in = rnd_pkt(100);
        rsp_in = mk_rsp(1'b1, $urandom);
        #1;
        chk("rst_w2e", w2e_out, '0);
        chk("rst_e2w", e2w_out, '0);
        chk("rst_wr", wr_out, '0);
        chk("rst_rdrq", rdrq_out, '0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_stat", stat, 16'h0);
        m_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // passthrough valid on the local direction for busy_n cycles; local responses on
    // cycles [loc_start, loc_start+loc_n); total_n cycles overall
    task automatic seq(input int busy_n, input int loc_start, input int loc_n, input int total_n);
        packet_t      pl, po;
        rdrs_packet_t r;
        for (int c = 0; c < total_n; c++) begin
            pl = rnd_pkt(c < busy_n ? 100 : 0);
            po = rnd_pkt(50);
            r  = (c >= loc_start && c < loc_start + loc_n) ? mk_rsp(1'b1, $urandom) : mk_rsp(1'b0, $urandom);
            if (tile[0]) step(po, pl, r);
            else step(pl, po, r);
        end
    endtask

    initial begin
        tile   = '0;
        w2e_in = '0;
        e2w_in = '0;
        rsp_in = '0;
        m_clear();
        @(negedge clk);
        do_reset();
        step(rnd_pkt(0), '0, '0);
        seq(0, 0, 0, 4);
        tile = 4'h3;
        step('0, '0, mk_rsp(1'b1, 32'hABCD));
        seq(0, 0, 0, 3);
        tile = 4'h2;
        seq(3, 1, 3, 10);
        seq(6, 1, 5, 12);
        do_reset();
        seq(4, 1, 5, 12);
        tile = 4'h5;
        do_reset();
        seq(4, 1, 2, 4);
        do_reset();
        seq(0, 0, 0, 6);
        for (int blk = 0; blk < 8; blk++) begin
            tile = TILE_SEL_ADDR_WIDTH'($urandom);
            do_reset();
            for (int c = 0; c < 200; c++)
                step(rnd_pkt(blk * 12), rnd_pkt(blk * 12), mk_rsp($urandom_range(99) < 60, $urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
